// File: rtl/bmf_part_err_sweep_ctrl.sv
// Error-characterisation sequencer for one approximated BMF partition: sweeps all
// input patterns through exact/approx instances and accumulates mismatch metrics.
//
// state | meaning
// IDLE  | waiting for start; results of the last sweep held
// RUN   | driving vec 0 .. 2^N_IN-1, one pattern per cycle
// DRAIN | vec held at last pattern while the final LAT results arrive
// DONE  | one-cycle done pulse, results final
module bmf_part_err_sweep_ctrl #(
  parameter int N_IN  = 9,
  parameter int N_OUT = 5,
  parameter int LAT   = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic                                 abort,
  output logic [N_IN-1:0]                      vec,
  input  logic [N_OUT-1:0]                     exact_po,
  input  logic [N_OUT-1:0]                     approx_po,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 aborted,
  output logic [N_IN:0]                        mismatch_cnt,
  output logic [N_IN+$clog2(N_OUT+1)-1:0]      hd_sum,
  output logic [N_OUT-1:0]                     max_err
);

  localparam int PW = $clog2(N_OUT + 1);
  localparam int HW = N_IN + PW;
  localparam logic [N_IN-1:0] VEC_LAST   = {N_IN{1'b1}};
  localparam logic [1:0]      DRAIN_LOAD = (LAT > 0) ? 2'(LAT - 1) : 2'd0;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        drain_cnt;
  logic              start_acc;
  logic              abort_hit;
  logic              tag;
  logic [N_OUT-1:0]  diff;
  logic [N_OUT-1:0]  abs_err;
  logic [PW-1:0]     pop;

  function automatic logic [PW-1:0] popcount(input logic [N_OUT-1:0] d);
    logic [PW-1:0] c;
    c = '0;
    for (int i = 0; i < N_OUT; i++) c = c + PW'(d[i]);
    return c;
  endfunction

  assign start_acc = (state_q == S_IDLE) && start && !abort;
  assign abort_hit = abort && ((state_q == S_RUN) || (state_q == S_DRAIN));
  assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);

  assign diff    = exact_po ^ approx_po;
  assign pop     = popcount(diff);
  assign abs_err = (exact_po >= approx_po) ? (exact_po - approx_po) : (approx_po - exact_po);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_acc) state_d = S_RUN;
      S_RUN: begin
        if (abort)                 state_d = S_IDLE;
        else if (vec == VEC_LAST)  state_d = (LAT > 0) ? S_DRAIN : S_DONE;
      end
      S_DRAIN: begin
        if (abort)                 state_d = S_IDLE;
        else if (drain_cnt == 2'd0) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // vec parks on the last pattern after the sweep and restarts only on an accepted start
  always_ff @(posedge clk) begin
    if (rst) begin
      vec       <= '0;
      drain_cnt <= 2'd0;
    end else begin
      if (start_acc)
        vec <= '0;
      else if ((state_q == S_RUN) && !abort && (vec != VEC_LAST))
        vec <= vec + 1'b1;

      if ((state_q == S_RUN) && (vec == VEC_LAST))
        drain_cnt <= DRAIN_LOAD;
      else if ((state_q == S_DRAIN) && (drain_cnt != 2'd0))
        drain_cnt <= drain_cnt - 2'd1;
    end
  end

  // Sample tag: follows vec through the same latency as the partition datapath
  if (LAT == 0) begin : g_nolat
    assign tag = (state_q == S_RUN);
  end else begin : g_lat
    logic [LAT-1:0] vpipe;
    always_ff @(posedge clk) begin
      if (rst || abort_hit) begin
        vpipe <= '0;
      end else begin
        vpipe[0] <= (state_q == S_RUN);
        for (int i = 1; i < LAT; i++) vpipe[i] <= vpipe[i-1];
      end
    end
    assign tag = vpipe[LAT-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aborted      <= 1'b0;
      mismatch_cnt <= '0;
      hd_sum       <= '0;
      max_err      <= '0;
    end else if (start_acc) begin
      aborted      <= 1'b0;
      mismatch_cnt <= '0;
      hd_sum       <= '0;
      max_err      <= '0;
    end else begin
      if (abort_hit) aborted <= 1'b1;
      // A sample landing on the abort edge is in flight and is dropped
      if (tag && !abort_hit) begin
        mismatch_cnt <= mismatch_cnt + {{N_IN{1'b0}}, (diff != '0)};
        hd_sum       <= hd_sum + {{N_IN{1'b0}}, pop};
        if (abs_err > max_err) max_err <= abs_err;
      end
    end
  end

endmodule
